mem_req_seq: RTL and testbench

- Host-side request sequencer that sits directly upstream of the memory-controller front-end stage; it drives that stage's ADDR[10:0]/CE/CSB/WEB/OEB/IDATA command inputs.
- Accepts single or burst read/write requests over a valid/ready handshake and issues one command beat per cycle, auto-incrementing the address.
- Tracks outstanding reads through a fixed-latency pipe, captures the returned bank data and presents it to the host as rdata/rvalid.
- Covers the 2 KiB space: 4 banks × 512 × 8, with the bank in ADDR[10:9].

---
 rtl/mem_req_seq_pkg.sv | 30 +++
 rtl/mem_rd_pipe.sv | 33 +++
 rtl/mem_req_seq.sv | 179 +++++++++++++++++
 tb/tb_mem_req_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_seq_pkg.sv
// Shared types and constants for the host-side memory request sequencer.
// Holds the FSM encoding, idle command levels and the bank field position.
package mem_req_seq_pkg;

    localparam int DEF_AW     = 11;
    localparam int DEF_DW     = 8;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_RD_LAT = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WR    = 2'b01,
        ST_RD    = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    // Command levels driven on bubbles and while idle
    localparam logic IDLE_CE  = 1'b0;
    localparam logic IDLE_CSB = 1'b1;
    localparam logic IDLE_WEB = 1'b1;
    localparam logic IDLE_OEB = 1'b1;

    localparam int BANK_HI = DEF_AW - 1;
    localparam int BANK_LO = DEF_AW - 2;

    function automatic logic [1:0] bank_of(input logic [DEF_AW-1:0] addr);
        return addr[BANK_HI:BANK_LO];
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency read tracker: a DEPTH-deep valid shift register with flush.
// The last stage marks the cycle in which returned read data must be captured.
module mem_rd_pipe #(
    parameter int DEPTH = 3
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic i_push,
    input  logic i_flush,
    output logic o_sample_en,
    output logic o_empty
);

    logic [DEPTH-1:0] r_stage;

    // Shift a one per issued read beat toward the sample stage
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_stage <= {DEPTH{1'b0}};
        end else if (i_flush) begin
            r_stage <= {DEPTH{1'b0}};
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_stage[i] <= r_stage[i-1];
            end
            r_stage[0] <= i_push;
        end
    end

    assign o_sample_en = r_stage[DEPTH-1];
    assign o_empty     = (r_stage == {DEPTH{1'b0}});

endmodule

// File: rtl/mem_req_seq.sv
// Host request sequencer: turns single/burst read-write requests into one
// registered memory command per cycle and returns read data as rdata/rvalid.
module mem_req_seq
    import mem_req_seq_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [AW-1:0]    req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [DW-1:0]    wd_data,
    output logic             rvalid,
    output logic [DW-1:0]    rdata,
    output logic             busy,
    output logic [AW-1:0]    ADDR,
    output logic             CE,
    output logic             CSB,
    output logic             WEB,
    output logic             OEB,
    output logic [DW-1:0]    IDATA,
    input  logic [DW-1:0]    ODATA
);

    localparam logic [AW-1:0]    ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

    state_t           r_state, w_state_nxt;
    logic [AW-1:0]    r_cur_addr, w_cur_addr_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
    logic [AW-1:0]    r_addr, w_addr_nxt;
    logic [DW-1:0]    r_idata, w_idata_nxt;
    logic             r_ce, r_csb, r_web, r_oeb;
    logic             w_ce_nxt, w_csb_nxt, w_web_nxt, w_oeb_nxt;
    logic             w_push, w_flush, w_sample_en, w_pipe_empty;
    logic             r_rvalid;
    logic [DW-1:0]    r_rdata;

    mem_rd_pipe #(.DEPTH(RD_LAT)) u_rd_pipe (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .i_push      (w_push),
        .i_flush     (w_flush),
        .o_sample_en (w_sample_en),
        .o_empty     (w_pipe_empty)
    );

    // Next state, burst bookkeeping and the command to register this cycle
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_addr_nxt = r_cur_addr;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_idata_nxt    = r_idata;
        w_ce_nxt       = IDLE_CE;
        w_csb_nxt      = IDLE_CSB;
        w_web_nxt      = IDLE_WEB;
        w_oeb_nxt      = IDLE_OEB;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_cur_addr_nxt = req_addr;
                    w_cnt_nxt      = req_len;
                    w_state_nxt    = req_we ? ST_WR : ST_RD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                // A missing data beat leaves a bubble and does not advance the address
                if (wd_valid) begin
                    w_ce_nxt       = 1'b1;
                    w_csb_nxt      = 1'b0;
                    w_web_nxt      = 1'b0;
                    w_oeb_nxt      = 1'b1;
                    w_addr_nxt     = r_cur_addr;
                    w_idata_nxt    = wd_data;
                    w_cur_addr_nxt = r_cur_addr + ADDR_ONE;
                    if (r_cnt == LEN_ZERO) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - LEN_ONE;
                    end
                end else begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_RD: begin
                w_ce_nxt       = 1'b1;
                w_csb_nxt      = 1'b0;
                w_web_nxt      = 1'b1;
                w_oeb_nxt      = 1'b0;
                w_addr_nxt     = r_cur_addr;
                w_push         = 1'b1;
                w_cur_addr_nxt = r_cur_addr + ADDR_ONE;
                if (r_cnt == LEN_ZERO) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt - LEN_ONE;
                end
            end
            ST_DRAIN: begin
                if (w_pipe_empty) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_flush     = 1'b1;
            end
        endcase
    end

    // State, burst tracking and registered command outputs
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= ST_IDLE;
            r_cur_addr <= {AW{1'b0}};
            r_cnt      <= LEN_ZERO;
            r_addr     <= {AW{1'b0}};
            r_idata    <= {DW{1'b0}};
            r_ce       <= IDLE_CE;
            r_csb      <= IDLE_CSB;
            r_web      <= IDLE_WEB;
            r_oeb      <= IDLE_OEB;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_addr <= w_cur_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_idata    <= w_idata_nxt;
            r_ce       <= w_ce_nxt;
            r_csb      <= w_csb_nxt;
            r_web      <= w_web_nxt;
            r_oeb      <= w_oeb_nxt;
        end
    end

    // Capture returned bank data when the matching read beat reaches the end of the pipe
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_rvalid <= 1'b0;
            r_rdata  <= {DW{1'b0}};
        end else begin
            r_rvalid <= w_sample_en;
            if (w_sample_en) begin
                r_rdata <= ODATA;
            end else begin
                r_rdata <= r_rdata;
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign wd_ready  = (r_state == ST_WR);
    assign busy      = (r_state != ST_IDLE) || !w_pipe_empty;
    assign ADDR      = r_addr;
    assign CE        = r_ce;
    assign CSB       = r_csb;
    assign WEB       = r_web;
    assign OEB       = r_oeb;
    assign IDATA     = r_idata;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_req_seq.sv
// Self-checking bench for mem_req_seq: a request table plus hand-written corner
// sequences, with command beats and read data checked against expectation queues.
module tb_mem_req_seq;

    logic        CLK;
    logic        RSTN;
    logic        req_valid, req_ready, req_we;
    logic [10:0] req_addr;
    logic [3:0]  req_len;
    logic        wd_valid, wd_ready;
    logic [7:0]  wd_data;
    logic        rvalid;
    logic [7:0]  rdata;
    logic        busy;
    logic [10:0] ADDR;
    logic        CE, CSB, WEB, OEB;
    logic [7:0]  IDATA;
    logic [7:0]  ODATA;
    logic [7:0]  d1, d2;

    mem_req_seq dut (
        .CLK(CLK), .RSTN(RSTN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .ADDR(ADDR), .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB),
        .IDATA(IDATA), .ODATA(ODATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: data for a beat is valid RD_LAT=3 edges after it is driven
    always @(posedge CLK) begin
        d1 <= ADDR[7:0];
        d2 <= d1;
    end
    assign ODATA = d2;

    typedef struct packed {
        logic [10:0] addr;
        logic        we;
        logic [7:0]  data;
    } cmd_t;

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [3:0]  len;
        logic [7:0]  seed;
        logic        stall;
        int          exp_beats;
        logic [10:0] exp_last;
    } vec_t;

    cmd_t        exp_cmd[$];
    logic [7:0]  exp_rd[$];
    vec_t        vecs[6];
    int          checks, errors;
    int          cyc;
    int          arm_ce, arm_rv;
    int          mon_beats;
    logic [10:0] mon_last_addr;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observe the DUT outputs for one cycle against the expectation queues
    task automatic monitor();
        cmd_t       e;
        logic [7:0] r;
        bit         ok;
        if (RSTN) begin
            if (CE) begin
                mon_beats++;
                mon_last_addr = ADDR;
                if (arm_ce < 0) arm_ce = cyc;
                if (exp_cmd.size() == 0) begin
                    chk(1'b0, "cmd_unexpected", {ADDR, WEB, IDATA}, 64'h0);
                end else begin
                    e  = exp_cmd.pop_front();
                    ok = (ADDR == e.addr) && (CSB == 1'b0) && (WEB == !e.we) &&
                         (OEB == e.we) && (!e.we || IDATA == e.data);
                    chk(ok, "cmd_beat", {ADDR, CSB, WEB, OEB, IDATA},
                        {e.addr, 1'b0, !e.we, e.we, e.data});
                end
            end else begin
                chk(CSB && WEB && OEB, "idle_cmd", {CSB, WEB, OEB}, 3'b111);
            end
            if (rvalid) begin
                if (arm_rv < 0) arm_rv = cyc;
                if (exp_rd.size() == 0) begin
                    chk(1'b0, "rvalid_unexpected", rdata, 64'h0);
                end else begin
                    r = exp_rd.pop_front();
                    chk(rdata == r, "rdata", rdata, r);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        monitor();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(!busy, name, busy, 1'b0);
    endtask

    task automatic do_req(input vec_t v);
        int          c0, b0, n;
        logic [10:0] a;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        chk(req_ready, "req_ready_wait", req_ready, 1'b1);
        c0 = cyc; b0 = mon_beats; arm_ce = -1; arm_rv = -1;
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_len = v.len;
        if (!v.we) begin
            for (int k = 0; k <= int'(v.len); k++) begin
                a = v.addr + 11'(k);
                exp_cmd.push_back({a, 1'b0, 8'h00});
                exp_rd.push_back(a[7:0]);
            end
        end
        tick();
        req_valid = 1'b0;
        if (v.we) begin
            for (int k = 0; k <= int'(v.len); k++) begin
                a = v.addr + 11'(k);
                wd_valid = 1'b1;
                wd_data  = v.seed + 8'(k);
                exp_cmd.push_back({a, 1'b1, wd_data});
                tick();
                if (v.stall && k != int'(v.len)) begin
                    wd_valid = 1'b0;
                    tick();
                end
            end
            wd_valid = 1'b0;
        end
        wait_idle("burst_done");
        tick();
        tick();
        chk(arm_ce == c0 + 2, "first_beat_latency", arm_ce - c0, 2);
        if (!v.we) chk(arm_rv - arm_ce == 3, "read_latency", arm_rv - arm_ce, 3);
        chk(mon_beats - b0 == v.exp_beats, "beat_count", mon_beats - b0, v.exp_beats);
        chk(mon_last_addr == v.exp_last, "last_addr", mon_last_addr, v.exp_last);
        chk(exp_cmd.size() == 0 && exp_rd.size() == 0, "queues_drained",
            exp_cmd.size() + exp_rd.size(), 0);
        chk(req_ready, "ready_after", req_ready, 1'b1);
    endtask

    initial begin
        int          c0, n;
        logic [31:0] rst_exp;

        vecs[0] = '{1'b1, 11'h005, 4'd0,  8'hA5, 1'b0, 1,  11'h005};
        vecs[1] = '{1'b1, 11'h7FE, 4'd2,  8'h3C, 1'b1, 3,  11'h000};
        vecs[2] = '{1'b0, 11'h1FE, 4'd3,  8'h00, 1'b0, 4,  11'h201};
        vecs[3] = '{1'b0, 11'h7FD, 4'd4,  8'h00, 1'b0, 5,  11'h001};
        vecs[4] = '{1'b1, 11'h1FF, 4'd15, 8'h5A, 1'b0, 16, 11'h20E};
        vecs[5] = '{1'b0, 11'h000, 4'd0,  8'h00, 1'b0, 1,  11'h000};
        rst_exp = {11'h000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};

        checks = 0; errors = 0; cyc = 0; arm_ce = -1; arm_rv = -1;
        mon_beats = 0; mon_last_addr = 11'h000;
        RSTN = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 11'h000;
        req_len = 4'h0; wd_valid = 1'b0; wd_data = 8'h00;

        tick();
        tick();
        chk({ADDR, CE, CSB, WEB, OEB, IDATA, rvalid, rdata} == rst_exp, "reset_state",
            {ADDR, CE, CSB, WEB, OEB, IDATA, rvalid, rdata}, rst_exp);
        chk(req_ready && !busy && !wd_ready, "reset_handshake", {req_ready, busy, wd_ready}, 3'b100);
        #2 RSTN = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_req(vecs[i]);
        end

        // Read then a held write request: accepted only after the drain completes
        c0 = cyc; arm_ce = -1; arm_rv = -1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h010; req_len = 4'h0;
        exp_cmd.push_back({11'h010, 1'b0, 8'h00});
        exp_rd.push_back(8'h10);
        tick();
        req_we = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk(cyc == c0 + 6, "b2b_ready_time", cyc - c0, 6);
        chk(!busy && exp_rd.size() == 0, "b2b_idle_at_accept", {busy, 8'(exp_rd.size())}, 0);
        wd_valid = 1'b1; wd_data = 8'hC3;
        exp_cmd.push_back({11'h010, 1'b1, 8'hC3});
        tick();
        req_valid = 1'b0;
        chk(!CE && CSB, "b2b_one_bubble", {CE, CSB}, 2'b01);
        tick();
        wd_valid = 1'b0;
        chk(CE && !WEB && ADDR == 11'h010 && IDATA == 8'hC3, "b2b_write_beat",
            {CE, WEB, ADDR, IDATA}, {1'b1, 1'b0, 11'h010, 8'hC3});
        wait_idle("b2b_done");

        // Reset in the middle of a read burst
        tick();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h300; req_len = 4'h7;
        for (int k = 0; k < 8; k++) begin
            exp_cmd.push_back({11'h300 + 11'(k), 1'b0, 8'h00});
            exp_rd.push_back(8'(k));
        end
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        #2 RSTN = 1'b0;
        #1;
        chk({ADDR, CE, CSB, WEB, OEB, IDATA, rvalid, rdata} == rst_exp, "midread_reset_state",
            {ADDR, CE, CSB, WEB, OEB, IDATA, rvalid, rdata}, rst_exp);
        chk(req_ready && !busy, "midread_reset_idle", {req_ready, busy}, 2'b10);
        exp_cmd.delete();
        exp_rd.delete();
        tick();
        tick();
        #2 RSTN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk(!rvalid, "no_rvalid_after_reset", rvalid, 1'b0);
        end
        chk(req_ready, "ready_after_reset", req_ready, 1'b1);

        // Long idle period with no requests
        for (int k = 0; k < 20; k++) begin
            tick();
            chk({CE, CSB, WEB, OEB, rvalid, busy} == 6'b011100, "idle_outputs",
                {CE, CSB, WEB, OEB, rvalid, busy}, 6'b011100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
